// File: rtl/servo_door_ctrl_if.sv
// rtl/servo_door_ctrl_if.sv - presence request and servo output bundle
// Ports: presence_open/presence_close (requests toward the controller),
//        pwm/door_open/moving (per-channel status from the controller).
// Modports: master drives requests, slave is the controller side.
interface servo_door_ctrl_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] presence_open;
    logic [CHANNELS-1:0] presence_close;
    logic [CHANNELS-1:0] pwm;
    logic [CHANNELS-1:0] door_open;
    logic [CHANNELS-1:0] moving;

    modport master (
        output presence_open,
        output presence_close,
        input  pwm,
        input  door_open,
        input  moving
    );

    modport slave (
        input  presence_open,
        input  presence_close,
        output pwm,
        output door_open,
        output moving
    );
endinterface

// File: rtl/servo_door_ctrl.sv
// rtl/servo_door_ctrl.sv - multi-channel slew-limited servo door controller
// Ports: clk, rst_n (async active-low), bus (servo_door_ctrl_if.slave):
//        presence_open/presence_close in, pwm/door_open/moving out.
// Optional macro SERVO_AUTO_CLOSE_EN adds a per-channel auto-close hold
// counter that closes an open door after HOLD_FRAMES frames without open.
module servo_door_ctrl #(
    parameter int CHANNELS    = 2,
    parameter int PERIOD_CYC  = 1_000_000,
    parameter int MIN_PW      = 50_000,
    parameter int MAX_PW      = 100_000,
    parameter int STEP        = 2_500,
    parameter int HOLD_FRAMES = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    servo_door_ctrl_if.slave bus
);
    localparam int W = $clog2(PERIOD_CYC);
    localparam logic [W-1:0] LAST   = W'(PERIOD_CYC - 1);
    localparam logic [W-1:0] MIN_W  = W'(MIN_PW);
    localparam logic [W-1:0] MAX_W  = W'(MAX_PW);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    // One extra bit so step arithmetic can be clamped without wrapping.
    localparam logic [W:0]   MIN_X  = (W+1)'(MIN_PW);
    localparam logic [W:0]   MAX_X  = (W+1)'(MAX_PW);
    localparam logic [W:0]   STEP_X = (W+1)'(STEP);
`ifdef SERVO_AUTO_CLOSE_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_X = HW'(HOLD_FRAMES);
`endif

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

    logic [CHANNELS-1:0] open_m, close_m, open_s, close_s;
    logic [W-1:0]        frame_cnt;
    logic                tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_m  <= '0;
            close_m <= '0;
            open_s  <= '0;
            close_s <= '0;
        end else begin
            open_m  <= bus.presence_open;
            close_m <= bus.presence_close;
            open_s  <= open_m;
            close_s <= close_m;
        end
    end

    assign tick = (frame_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    frame_cnt <= '0;
        else if (tick) frame_cnt <= '0;
        else           frame_cnt <= frame_cnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t       state_q, state_d;
        logic [W-1:0] pw_q, pw_d, pw_up, pw_dn;
        logic [W:0]   up_sum;
        logic         pwm_q, door_q, moving_q;
`ifdef SERVO_AUTO_CLOSE_EN
        logic [HW-1:0] hold_q, hold_d, hold_inc;
`endif

        always_comb begin
            up_sum = {1'b0, pw_q} + STEP_X;
            pw_up  = (up_sum >= MAX_X) ? MAX_W : up_sum[W-1:0];
            pw_dn  = ({1'b0, pw_q} <= MIN_X + STEP_X) ? MIN_W : pw_q - STEP_W;
        end

        always_comb begin
            state_d = state_q;
            pw_d    = pw_q;
`ifdef SERVO_AUTO_CLOSE_EN
            hold_d   = hold_q;
            hold_inc = hold_q + 1'b1;
            if (tick && open_s[i]) hold_d = '0;
`endif
            if (tick) begin
                case (state_q)
                    CLOSED: begin
                        if (open_s[i]) state_d = OPENING;
                    end
                    OPENING: begin
                        // A close request only wins when open is absent.
                        if (close_s[i] && !open_s[i]) begin
                            state_d = CLOSING;
                        end else begin
                            pw_d = pw_up;
                            if (pw_up == MAX_W) state_d = OPEN;
                        end
                    end
                    OPEN: begin
                        if (close_s[i] && !open_s[i]) begin
                            state_d = CLOSING;
                        end
`ifdef SERVO_AUTO_CLOSE_EN
                        else if (!open_s[i]) begin
                            hold_d = hold_inc;
                            if (hold_inc == HOLD_X) state_d = CLOSING;
                        end
`endif
                    end
                    CLOSING: begin
                        // Open always reverses a closing door immediately.
                        if (open_s[i]) begin
                            state_d = OPENING;
                        end else begin
                            pw_d = pw_dn;
                            if (pw_dn == MIN_W) state_d = CLOSED;
                        end
                    end
                    default: state_d = CLOSED;
                endcase
            end
`ifdef SERVO_AUTO_CLOSE_EN
            if (state_d == OPEN && state_q != OPEN) hold_d = '0;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= CLOSED;
                pw_q     <= MIN_W;
                pwm_q    <= 1'b0;
                door_q   <= 1'b0;
                moving_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                pw_q     <= pw_d;
                // pw only changes on the last cycle of a frame, where this
                // compare is already low, so no frame mixes two widths.
                pwm_q    <= (frame_cnt < pw_q);
                door_q   <= (state_d == OPEN);
                moving_q <= (state_d == OPENING) || (state_d == CLOSING);
            end
        end

`ifdef SERVO_AUTO_CLOSE_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hold_q <= '0;
            else        hold_q <= hold_d;
        end
`endif

        assign bus.pwm[i]       = pwm_q;
        assign bus.door_open[i] = door_q;
        assign bus.moving[i]    = moving_q;
    end
endmodule

// File: tb/tb_servo_door_ctrl.sv
// tb/tb_servo_door_ctrl.sv - scoreboard bench for servo_door_ctrl
module tb_servo_door_ctrl;
    localparam int CH   = 2;
    localparam int PER  = 1000;
    localparam int MINP = 50;
    localparam int MAXP = 100;
    localparam int STP  = 10;
    localparam int HOLD = 3;
    localparam int NROW = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    servo_door_ctrl_if #(.CHANNELS(CH)) bus ();

    servo_door_ctrl #(
        .CHANNELS   (CH),
        .PERIOD_CYC (PER),
        .MIN_PW     (MINP),
        .MAX_PW     (MAXP),
        .STEP       (STP),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];

    // Row i is applied mid-frame i; exp* is the width of frame i+1.
    bit row_o0 [NROW] = '{0,0,1,1,1,0,0,0,0,1,1,1,1,1,1,0,0,0,0};
    bit row_c0 [NROW] = '{0,0,0,0,0,1,1,1,0,1,1,1,1,1,1,0,0,0,0};
    bit row_o1 [NROW] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1};
`ifdef SERVO_AUTO_CLOSE_EN
    int row_e0 [NROW] = '{50,50,50,60,70,70,60,50,50,50,60,70,80,90,100,100,100,100,90};
`else
    int row_e0 [NROW] = '{50,50,50,60,70,70,60,50,50,50,60,70,80,90,100,100,100,100,100};
`endif
    int row_e1 [NROW] = '{50,50,50,50,50,50,50,50,50,50,50,50,50,50,50,50,60,70,80};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int e0, input int e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic pop_check(input int ch, input int width);
        int sz;
        int exp;
        sz = (ch == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse_ch%0d: got width %0d, expected no pulse", ch, width);
        end else begin
            exp = (ch == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("width_ch%0d", ch), width, exp);
        end
    endtask

    // Monitor: measures every pulse and its period, pops the expected width.
    int cnt [CH];
    int last_rise [CH];
    logic prev [CH];
    int cyc = 0;

    always @(negedge clk) begin
        cyc++;
        for (int ch = 0; ch < CH; ch++) begin
            if (!rst_n) begin
                cnt[ch]       = 0;
                last_rise[ch] = -1;
                prev[ch]      = 1'b0;
            end else begin
                if (bus.pwm[ch] && !prev[ch]) begin
                    if (last_rise[ch] >= 0)
                        check($sformatf("period_ch%0d", ch), cyc - last_rise[ch], PER);
                    last_rise[ch] = cyc;
                end
                if (bus.pwm[ch]) begin
                    cnt[ch]++;
                end else if (cnt[ch] > 0) begin
                    pop_check(ch, cnt[ch]);
                    cnt[ch] = 0;
                end
                prev[ch] = bus.pwm[ch];
            end
        end
    end

    initial begin
        bus.presence_open  = '0;
        bus.presence_close = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm", bus.pwm, 0);
        check("reset_door_open", bus.door_open, 0);
        check("reset_moving", bus.moving, 0);

        push(MINP, MINP);
        rst_n = 1'b1;
        repeat (PER / 2) @(negedge clk);
        check("idle_door_open", bus.door_open, 0);
        check("idle_moving", bus.moving, 0);

        for (int r = 0; r < NROW; r++) begin
            bus.presence_open  = {row_o1[r], row_o0[r]};
            bus.presence_close = {1'b0, row_c0[r]};
            push(row_e0[r], row_e1[r]);
            repeat (PER) @(negedge clk);
            if (r == 2) begin
                check("opening_moving0", bus.moving[0], 1);
                check("opening_door0", bus.door_open[0], 0);
            end
            if (r == 8) begin
                check("closed_moving0", bus.moving[0], 0);
                check("closed_door0", bus.door_open[0], 0);
            end
            if (r == 14) begin
                check("open_door0", bus.door_open[0], 1);
                check("open_moving0", bus.moving[0], 0);
                check("open_ch1_idle", {bus.door_open[1], bus.moving[1]}, 0);
            end
            if (r == 18) begin
`ifdef SERVO_AUTO_CLOSE_EN
                check("autoclose_door0", bus.door_open[0], 0);
                check("autoclose_moving0", bus.moving[0], 1);
`else
                check("hold_door0", bus.door_open[0], 1);
                check("hold_moving0", bus.moving[0], 0);
`endif
                check("ramp_moving1", bus.moving[1], 1);
            end
        end

        // 40 cycles into the next frame both pulses are high.
        repeat (PER / 2 + 40) @(negedge clk);
        check("pre_reset_pwm", bus.pwm, 2'b11);
        rst_n = 1'b0;
        bus.presence_open  = '0;
        bus.presence_close = '0;
        #1;
        check("midramp_reset_pwm", bus.pwm, 0);
        check("midramp_reset_door", bus.door_open, 0);
        check("midramp_reset_moving", bus.moving, 0);
        repeat (5) @(negedge clk);

        push(MINP, MINP);
        rst_n = 1'b1;
        repeat (PER / 2) @(negedge clk);
        check("post_reset_door", bus.door_open, 0);
        check("post_reset_moving", bus.moving, 0);
        push(MINP, MINP);
        repeat (PER) @(negedge clk);

        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
